// File: rtl/hcr_arb_pkg.sv
// Shared types and helpers for the hcr read-stream arbiter: FSM states,
// header layout and the round-robin picker.
package hcr_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_NSRC = 8;

  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_MAGIC_LSB = 24;
  localparam int         HDR_CONT_BIT  = 23;
  localparam int         HDR_ID_LSB    = 16;
  localparam int         HDR_SEQ_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2,
    ST_EOF  = 2'd3
  } arb_state_e;

  // First valid source at or after ptr, wrapping modulo nsrc.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         nsrc);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_NSRC; k++) begin
      idx = 3'((int'(ptr) + k) % nsrc);
      if (!found && (k < nsrc) && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [WORD_W-1:0] build_hdr(input logic        cont,
                                                  input logic [6:0]  id,
                                                  input logic [15:0] seq);
    logic [WORD_W-1:0] hdr;
    hdr = 32'h0000_0000;
    hdr[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    hdr[HDR_CONT_BIT]       = cont;
    hdr[HDR_ID_LSB +: 7]    = id;
    hdr[HDR_SEQ_LSB +: 16]  = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/hcr_out_fifo2.sv
// Two-entry output buffer feeding the Xillybus read side: registered data,
// registered empty flag and a sticky read-while-empty error.
module hcr_out_fifo2
  import hcr_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              rden,
  output logic              room,
  output logic              empty,
  output logic [WORD_W-1:0] data,
  output logic              rden_err
);

  logic [1:0][WORD_W-1:0] mem_q, mem_d;
  logic [1:0]             count_q, count_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [WORD_W-1:0]      data_q, data_d;
  logic                   empty_q, empty_d;
  logic                   err_q, err_d;
  logic                   pop_s, push_ok_s, room_s;

  // Next-state for storage, pointers, occupancy and flags.
  always_comb begin
    room_s    = (count_q < 2'd2) | (rden & ~empty_q);
    pop_s     = rden & ~empty_q & ~flush;
    push_ok_s = push & room_s & ~flush;
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    data_d    = data_q;
    count_d   = count_q;
    err_d     = err_q | (rden & empty_q);
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (pop_s) begin
        data_d   = mem_q[rd_ptr_q];
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        data_d = data_q;
      end
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + {1'b0, push_ok_s} - {1'b0, pop_s};
    end
    empty_d = (count_d == 2'd0);
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      data_q   <= 32'h0000_0000;
      empty_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      data_q   <= data_d;
      empty_q  <= empty_d;
      err_q    <= err_d;
    end
  end

  assign room     = room_s;
  assign empty    = empty_q;
  assign data     = data_q;
  assign rden_err = err_q;

endmodule

// File: rtl/hcr_stream_arbiter.sv
// Round-robin burst arbiter sharing the hcr read stream between NSRC producers;
// every burst is preceded by a demux header word for host software.
module hcr_stream_arbiter
  import hcr_arb_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int MAX_BURST = 256
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst,
  input  logic [32*NSRC-1:0]   src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC-1:0]      src_last,
  output logic [NSRC-1:0]      src_ready,
  input  logic                 eof_req,
  input  logic                 user_r_hcr_open,
  input  logic                 user_r_hcr_rden,
  output logic [31:0]          user_r_hcr_data,
  output logic                 user_r_hcr_empty,
  output logic                 user_r_hcr_eof,
  output logic [NSRC-1:0]      grant,
  output logic                 rden_err
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_e             state_q, state_d;
  logic [NSRC-1:0]        grant_q, grant_d;
  logic [2:0]             idx_q, idx_d;
  logic [2:0]             rr_q, rr_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [NSRC-1:0][15:0]  seq_q, seq_d;
  logic [NSRC-1:0]        cont_q, cont_d;
  logic                   eof_q, eof_d;
  logic                   armed_q, armed_d;

  logic [WORD_W-1:0]      sel_data_s;
  logic                   sel_valid_s, sel_last_s, sel_cont_s;
  logic [15:0]            sel_seq_s;
  logic [2:0]             pick_s;
  logic [NSRC-1:0]        ready_s;
  logic                   push_s, room_s, fifo_empty_s;
  logic [WORD_W-1:0]      push_data_s;

  // Route the granted producer's word and its seq/cont bookkeeping.
  always_comb begin
    sel_data_s = 32'h0000_0000;
    sel_cont_s = 1'b0;
    sel_seq_s  = 16'd0;
    for (int i = 0; i < NSRC; i++) begin
      sel_data_s = sel_data_s | (grant_q[i] ? src_data[32*i +: 32] : 32'h0000_0000);
      sel_cont_s = (idx_q == 3'(i)) ? cont_q[i] : sel_cont_s;
      sel_seq_s  = (idx_q == 3'(i)) ? seq_q[i]  : sel_seq_s;
    end
    sel_valid_s = |(src_valid & grant_q);
    sel_last_s  = |(src_last & grant_q);
    pick_s      = rr_pick(8'(src_valid), rr_q, NSRC);
  end

  // Burst FSM next-state; closing the stream aborts any state back to idle.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    bcnt_d      = bcnt_q;
    seq_d       = seq_q;
    cont_d      = cont_q;
    eof_d       = 1'b0;
    armed_d     = armed_q | ~eof_req;
    push_s      = 1'b0;
    push_data_s = sel_data_s;
    ready_s     = '0;
    if (!user_r_hcr_open) begin
      state_d = ST_IDLE;
      grant_d = '0;
      if ((state_q == ST_BODY) && (bcnt_q != '0)) begin
        cont_d = cont_q | grant_q;
      end else begin
        cont_d = cont_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|src_valid) begin
            idx_d   = pick_s;
            grant_d = {{(NSRC-1){1'b0}}, 1'b1} << pick_s;
            state_d = ST_HDR;
          end else if (eof_req && armed_q) begin
            state_d = ST_EOF;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (room_s) begin
            push_s      = 1'b1;
            push_data_s = build_hdr(sel_cont_s, {4'd0, idx_q}, sel_seq_s);
            bcnt_d      = '0;
            state_d     = ST_BODY;
          end else begin
            state_d = ST_HDR;
          end
        end
        ST_BODY: begin
          ready_s = room_s ? grant_q : '0;
          if (room_s && sel_valid_s) begin
            push_s = 1'b1;
            bcnt_d = bcnt_q + BW'(1);
            if (sel_last_s || (bcnt_q == BW'(MAX_BURST - 1))) begin
              cont_d  = sel_last_s ? (cont_q & ~grant_q) : (cont_q | grant_q);
              for (int i = 0; i < NSRC; i++) begin
                seq_d[i] = grant_q[i] ? (seq_q[i] + 16'd1) : seq_q[i];
              end
              rr_d    = (idx_q == 3'(NSRC - 1)) ? 3'd0 : (idx_q + 3'd1);
              grant_d = '0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BODY;
            end
          end else begin
            state_d = ST_BODY;
          end
        end
        ST_EOF: begin
          if (fifo_empty_s) begin
            eof_d   = 1'b1;
            armed_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_EOF;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  // FSM, arbitration and per-source bookkeeping registers.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= 3'd0;
      rr_q    <= 3'd0;
      bcnt_q  <= '0;
      seq_q   <= '0;
      cont_q  <= '0;
      eof_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      bcnt_q  <= bcnt_d;
      seq_q   <= seq_d;
      cont_q  <= cont_d;
      eof_q   <= eof_d;
      armed_q <= armed_d;
    end
  end

  hcr_out_fifo2 u_out_fifo (
    .clk       (bus_clk),
    .rst       (bus_rst),
    .flush     (~user_r_hcr_open),
    .push      (push_s),
    .push_data (push_data_s),
    .rden      (user_r_hcr_rden),
    .room      (room_s),
    .empty     (fifo_empty_s),
    .data      (user_r_hcr_data),
    .rden_err  (rden_err)
  );

  assign src_ready        = ready_s;
  assign user_r_hcr_empty = fifo_empty_s;
  assign user_r_hcr_eof   = eof_q;
  assign grant            = grant_q;

endmodule

// File: tb/tb_hcr_stream_arbiter.sv
// Directed bench for hcr_stream_arbiter: producer queues and a host reader
// model drive the DUT; each test task checks hand-computed words inline.
module tb_hcr_stream_arbiter;

  localparam int NSRC      = 4;
  localparam int MAX_BURST = 4;

  logic                bus_clk = 1'b0;
  logic                bus_rst = 1'b1;
  logic [32*NSRC-1:0]  src_data;
  logic [NSRC-1:0]     src_valid, src_last, src_ready;
  logic                eof_req = 1'b0;
  logic                open = 1'b0;
  logic                rden;
  logic [31:0]         rdata;
  logic                empty, eof;
  logic [NSRC-1:0]     grant;
  logic                rden_err;

  int errors = 0;
  int checks = 0;

  logic [32:0]     srcq [NSRC][$];
  logic [31:0]     rx [$];
  int              acc_cnt [NSRC];
  logic            host_en = 1'b0;
  logic            force_rden = 1'b0;
  int              eof_cnt = 0;
  int              eof_bad = 0;
  int              eof_rx_size = 0;
  logic [NSRC-1:0] acc;
  logic            popped;

  hcr_stream_arbiter #(.NSRC(NSRC), .MAX_BURST(MAX_BURST)) dut (
    .bus_clk          (bus_clk),
    .bus_rst          (bus_rst),
    .src_data         (src_data),
    .src_valid        (src_valid),
    .src_last         (src_last),
    .src_ready        (src_ready),
    .eof_req          (eof_req),
    .user_r_hcr_open  (open),
    .user_r_hcr_rden  (rden),
    .user_r_hcr_data  (rdata),
    .user_r_hcr_empty (empty),
    .user_r_hcr_eof   (eof),
    .grant            (grant),
    .rden_err         (rden_err)
  );

  always #5 bus_clk = ~bus_clk;

  // Producers and host: drive at negedge, sample just before posedge, retire after it.
  initial begin
    rden = 1'b0; src_valid = '0; src_last = '0; src_data = '0;
    for (int i = 0; i < NSRC; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge bus_clk);
      rden = force_rden | (host_en & ~empty);
      for (int i = 0; i < NSRC; i++) begin
        if (srcq[i].size() > 0) begin
          src_valid[i] = 1'b1;
          src_data[32*i +: 32] = srcq[i][0][31:0];
          src_last[i] = srcq[i][0][32];
        end else begin
          src_valid[i] = 1'b0;
          src_data[32*i +: 32] = 32'h0;
          src_last[i] = 1'b0;
        end
      end
      #4;
      acc = src_valid & src_ready;
      popped = rden & ~empty;
      if (eof === 1'b1) begin
        eof_cnt++;
        eof_rx_size = rx.size();
        if (empty !== 1'b1) eof_bad++;
      end
      @(posedge bus_clk);
      #1;
      for (int i = 0; i < NSRC; i++) begin
        if (acc[i] && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
          acc_cnt[i]++;
        end
      end
      if (popped) rx.push_back(rdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge bus_clk);
    bus_rst = 1'b1; open = 1'b0; host_en = 1'b0; force_rden = 1'b0; eof_req = 1'b0;
    repeat (2) @(posedge bus_clk);
    #2 bus_rst = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      srcq[i].delete();
      acc_cnt[i] = 0;
    end
    rx.delete();
    eof_cnt = 0; eof_bad = 0; eof_rx_size = 0;
  endtask

  task automatic wait_rx(input int n, input int budget, output int cycles);
    cycles = 0;
    while (rx.size() < n && cycles < budget) begin
      @(posedge bus_clk); #2;
      cycles++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty);
    if (empty !== 1'b1) errors++;
    checks++; if (eof !== 1'b0) begin $display("FAIL reset_eof: got %b expected 0", eof); errors++; end
    checks++; if (grant !== 4'b0000) begin $display("FAIL reset_grant: got %b expected 0000", grant); errors++; end
    checks++; if (src_ready !== 4'b0000) begin $display("FAIL reset_ready: got %b expected 0000", src_ready); errors++; end
    checks++; if (rden_err !== 1'b0) begin $display("FAIL reset_rden_err: got %b expected 0", rden_err); errors++; end
    checks++; if (rdata !== 32'h0) begin $display("FAIL reset_data: got %h expected 00000000", rdata); errors++; end
    open = 1'b1;
    srcq[0].push_back({1'b0, 32'hCAFE_0001});
    srcq[0].push_back({1'b1, 32'hCAFE_0002});
    repeat (5) @(posedge bus_clk);
    #2;
    checks++; if (grant !== 4'b0001) begin $display("FAIL midburst_grant: got %b expected 0001", grant); errors++; end
    @(negedge bus_clk);
    bus_rst = 1'b1;
    @(posedge bus_clk); #2;
    checks++; if (grant !== 4'b0000 || empty !== 1'b1) begin
      $display("FAIL midburst_reset: got grant=%b empty=%b expected grant=0000 empty=1", grant, empty); errors++;
    end
    bus_rst = 1'b0;
    open = 1'b0;
  endtask

  task automatic test_single_burst();
    logic [31:0] exp [6];
    int cyc;
    exp = '{32'hA500_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'hA500_0001, 32'h1111_0004};
    do_reset();
    open = 1'b1; host_en = 1'b1;
    srcq[0].push_back({1'b0, 32'h1111_0001});
    srcq[0].push_back({1'b0, 32'h1111_0002});
    srcq[0].push_back({1'b1, 32'h1111_0003});
    wait_rx(4, 40, cyc);
    repeat (3) @(posedge bus_clk);
    #2;
    checks++; if (grant !== 4'b0000) begin $display("FAIL single_grant_idle: got %b expected 0000", grant); errors++; end
    srcq[0].push_back({1'b1, 32'h1111_0004});
    wait_rx(6, 40, cyc);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rx.size() <= k || rx[k] !== exp[k]) begin
        $display("FAIL single_word%0d: got %h expected %h", k, (rx.size() > k) ? rx[k] : 32'hxxxx_xxxx, exp[k]); errors++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp [10];
    int cyc;
    exp = '{32'hA500_0000, 32'hAAAA_0000, 32'hA501_0000, 32'hBBBB_0000, 32'hA502_0000,
            32'hCCCC_0000, 32'hA503_0000, 32'hDDDD_0000, 32'hA500_0001, 32'hAAAA_0001};
    do_reset();
    open = 1'b1; host_en = 1'b1;
    srcq[0].push_back({1'b1, 32'hAAAA_0000});
    srcq[0].push_back({1'b1, 32'hAAAA_0001});
    srcq[1].push_back({1'b1, 32'hBBBB_0000});
    srcq[2].push_back({1'b1, 32'hCCCC_0000});
    srcq[3].push_back({1'b1, 32'hDDDD_0000});
    wait_rx(10, 60, cyc);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rx.size() <= k || rx[k] !== exp[k]) begin
        $display("FAIL rr_word%0d: got %h expected %h", k, (rx.size() > k) ? rx[k] : 32'hxxxx_xxxx, exp[k]); errors++;
      end
    end
    checks++; if (cyc > 20) begin $display("FAIL rr_throughput: got %0d cycles expected at most 20", cyc); errors++; end
  endtask

  task automatic test_max_burst();
    logic [31:0] exp [8];
    int cyc;
    exp = '{32'hA501_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003, 32'hE000_0004,
            32'hA581_0001, 32'hE000_0005, 32'hE000_0006};
    do_reset();
    open = 1'b1; host_en = 1'b1;
    for (int k = 1; k <= 6; k++) srcq[1].push_back({(k == 6), 32'hE000_0000 + 32'(k)});
    wait_rx(8, 60, cyc);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rx.size() <= k || rx[k] !== exp[k]) begin
        $display("FAIL maxburst_word%0d: got %h expected %h", k, (rx.size() > k) ? rx[k] : 32'hxxxx_xxxx, exp[k]); errors++;
      end
    end
  endtask

  task automatic test_open_drop();
    logic [31:0] exp [4];
    int n, cyc;
    exp = '{32'hA582_0000, 32'hF000_0003, 32'hF000_0004, 32'hF000_0005};
    do_reset();
    open = 1'b1; host_en = 1'b1;
    for (int k = 1; k <= 5; k++) srcq[2].push_back({(k == 5), 32'hF000_0000 + 32'(k)});
    n = 0;
    while (acc_cnt[2] < 2 && n < 40) begin @(posedge bus_clk); #2; n++; end
    checks++; if (acc_cnt[2] != 2) begin $display("FAIL drop_taken: got %0d expected 2", acc_cnt[2]); errors++; end
    open = 1'b0; host_en = 1'b0;
    #1;
    checks++; if (src_ready !== 4'b0000) begin $display("FAIL drop_ready: got %b expected 0000", src_ready); errors++; end
    @(posedge bus_clk); #2;
    checks++; if (empty !== 1'b1) begin $display("FAIL drop_empty: got %b expected 1", empty); errors++; end
    checks++; if (grant !== 4'b0000) begin $display("FAIL drop_grant: got %b expected 0000", grant); errors++; end
    checks++; if (srcq[2].size() != 3) begin $display("FAIL drop_kept: got %0d expected 3", srcq[2].size()); errors++; end
    rx.delete();
    open = 1'b1; host_en = 1'b1;
    wait_rx(4, 40, cyc);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx.size() <= k || rx[k] !== exp[k]) begin
        $display("FAIL reopen_word%0d: got %h expected %h", k, (rx.size() > k) ? rx[k] : 32'hxxxx_xxxx, exp[k]); errors++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp [5];
    int cyc;
    exp = '{32'hA503_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003, 32'h6000_0004};
    do_reset();
    open = 1'b1; host_en = 1'b0;
    for (int k = 1; k <= 4; k++) srcq[3].push_back({(k == 4), 32'h6000_0000 + 32'(k)});
    repeat (10) @(posedge bus_clk);
    #2;
    checks++; if (acc_cnt[3] != 1) begin $display("FAIL stall_taken: got %0d expected 1", acc_cnt[3]); errors++; end
    checks++; if (src_ready !== 4'b0000) begin $display("FAIL stall_ready: got %b expected 0000", src_ready); errors++; end
    checks++; if (grant !== 4'b1000) begin $display("FAIL stall_grant: got %b expected 1000", grant); errors++; end
    host_en = 1'b1;
    wait_rx(5, 40, cyc);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx.size() <= k || rx[k] !== exp[k]) begin
        $display("FAIL stall_word%0d: got %h expected %h", k, (rx.size() > k) ? rx[k] : 32'hxxxx_xxxx, exp[k]); errors++;
      end
    end
    repeat (4) @(posedge bus_clk);
    #2;
    checks++; if (rx.size() != 5) begin $display("FAIL stall_count: got %0d expected 5", rx.size()); errors++; end
    checks++; if (rden_err !== 1'b0) begin $display("FAIL err_before: got %b expected 0", rden_err); errors++; end
    force_rden = 1'b1;
    @(posedge bus_clk); #2;
    force_rden = 1'b0;
    checks++; if (rden_err !== 1'b1) begin $display("FAIL err_after: got %b expected 1", rden_err); errors++; end
  endtask

  task automatic test_eof();
    logic [31:0] exp [3];
    int cyc, n;
    exp = '{32'hA500_0000, 32'h7000_0001, 32'h7000_0002};
    do_reset();
    open = 1'b1; host_en = 1'b1; eof_req = 1'b1;
    repeat (8) @(posedge bus_clk);
    #2;
    checks++; if (eof_cnt != 1) begin $display("FAIL eof_pulse: got %0d cycles expected 1", eof_cnt); errors++; end
    checks++; if (eof_bad != 0) begin $display("FAIL eof_empty: got %0d non-empty eof cycles expected 0", eof_bad); errors++; end
    eof_req = 1'b0;
    repeat (2) @(posedge bus_clk);
    #2;
    eof_cnt = 0;
    srcq[0].push_back({1'b0, 32'h7000_0001});
    srcq[0].push_back({1'b1, 32'h7000_0002});
    eof_req = 1'b1;
    wait_rx(3, 40, cyc);
    n = 0;
    while (eof_cnt < 1 && n < 20) begin @(posedge bus_clk); #2; n++; end
    repeat (4) @(posedge bus_clk);
    #2;
    eof_req = 1'b0;
    checks++; if (eof_cnt != 1) begin $display("FAIL eof2_pulse: got %0d cycles expected 1", eof_cnt); errors++; end
    checks++; if (eof_rx_size != 3) begin $display("FAIL eof2_after_drain: got %0d words before eof expected 3", eof_rx_size); errors++; end
    checks++; if (eof_bad != 0) begin $display("FAIL eof2_empty: got %0d expected 0", eof_bad); errors++; end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx.size() <= k || rx[k] !== exp[k]) begin
        $display("FAIL eof2_word%0d: got %h expected %h", k, (rx.size() > k) ? rx[k] : 32'hxxxx_xxxx, exp[k]); errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_open_drop();
    test_stall();
    test_eof();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
